// File: rtl/gba_mem_pkg.sv
// Shared types and wait-state tables for the GBA bus responder.
// Consumed by gba_ws_decode and gba_mem_responder.
package gba_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DATA,
    DATA2
  } state_e;

  typedef enum logic [3:0] {
    RG_BIOS,
    RG_IWRAM,
    RG_IO,
    RG_OAM,
    RG_EWRAM,
    RG_VRAM,
    RG_GP0,
    RG_GP1,
    RG_GP2,
    RG_SRAM,
    RG_NONE
  } region_e;

  typedef enum logic [1:0] {
    BW_32,
    BW_16,
    BW_8
  } bw_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  function automatic logic [3:0] n_ws_lut(input logic [1:0] f);
    case (f)
      2'd0:    return 4'd4;
      2'd1:    return 4'd3;
      2'd2:    return 4'd2;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic [3:0] s_ws_lut(input logic fast,
                                          input logic [3:0] slow);
    return fast ? 4'd1 : slow;
  endfunction

  function automatic logic [31:0] size_bytes(input logic [1:0] s);
    case (s)
      SIZE_BYTE: return 32'd1;
      SIZE_HALF: return 32'd2;
      default:   return 32'd4;
    endcase
  endfunction

endpackage

// File: rtl/gba_mem_responder_if.sv
// Master-side bus bundle of the GBA memory responder.
// The master drives the access, the responder answers with data and stall.
interface gba_mem_responder_if;
  logic        bus_active;
  logic [31:0] bus_addr;
  logic [1:0]  bus_size;
  logic        bus_wen;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        mem_wait;

  modport master (
    output bus_active, bus_addr, bus_size, bus_wen, bus_wdata,
    input  bus_rdata, mem_wait
  );

  modport slave (
    input  bus_active, bus_addr, bus_size, bus_wen, bus_wdata,
    output bus_rdata, mem_wait
  );
endinterface

// File: rtl/gba_ws_decode.sv
// Region, bus width and N/S wait-state decode from address and WAITCNT.
// Purely combinational.
module gba_ws_decode
  import gba_mem_pkg::*;
#(
  parameter int EWRAM_WS = 2,
  parameter int VRAM_WS  = 0
) (
  input  logic [7:0]  addr_hi,
  input  logic [10:0] waitcnt,
  output region_e     region,
  output bw_e         width,
  output logic [3:0]  n_ws,
  output logic [3:0]  s_ws
);

  always_comb begin
    region = RG_NONE;
    width  = BW_32;
    n_ws   = 4'd0;
    s_ws   = 4'd0;
    if (addr_hi[7:4] == 4'h0) begin
      case (addr_hi[3:0])
        4'h0: region = RG_BIOS;
        4'h3: region = RG_IWRAM;
        4'h4: region = RG_IO;
        4'h7: region = RG_OAM;
        4'h2: begin
          region = RG_EWRAM;
          width  = BW_16;
          n_ws   = 4'(EWRAM_WS);
          s_ws   = 4'(EWRAM_WS);
        end
        4'h5, 4'h6: begin
          region = RG_VRAM;
          width  = BW_16;
          n_ws   = 4'(VRAM_WS);
          s_ws   = 4'(VRAM_WS);
        end
        4'h8, 4'h9: begin
          region = RG_GP0;
          width  = BW_16;
          n_ws   = n_ws_lut(waitcnt[3:2]);
          s_ws   = s_ws_lut(waitcnt[4], 4'd2);
        end
        4'hA, 4'hB: begin
          region = RG_GP1;
          width  = BW_16;
          n_ws   = n_ws_lut(waitcnt[6:5]);
          s_ws   = s_ws_lut(waitcnt[7], 4'd4);
        end
        4'hC, 4'hD: begin
          region = RG_GP2;
          width  = BW_16;
          n_ws   = n_ws_lut(waitcnt[9:8]);
          s_ws   = s_ws_lut(waitcnt[10], 4'd8);
        end
        4'hE: begin
          region = RG_SRAM;
          width  = BW_8;
          n_ws   = n_ws_lut(waitcnt[1:0]);
          s_ws   = n_ws_lut(waitcnt[1:0]);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/gba_mem_responder.sv
// GBA bus responder: wait states, lane steering, 16-bit word split.
// GBA_MEM_OPEN_BUS_EN: unmapped reads return the last completed read data.
module gba_mem_responder
  import gba_mem_pkg::*;
#(
  parameter int EWRAM_WS = 2,
  parameter int VRAM_WS  = 0
) (
  input  logic                 clk,
  input  logic                 rst_b,
  gba_mem_responder_if.slave   bus,
  input  logic [15:0]          waitcnt,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [3:0]           mem_be,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata
);

  region_e     region;
  bw_e         width;
  logic [3:0]  n_ws, s_ws, ws_first;
  state_e      state_q, state_d;
  logic [3:0]  cnt, cnt_d;
  logic        second, second_d;
  logic [15:0] lo_half, lo_half_d;
  logic [31:0] next_addr, last_rd;
  logic        issue, hi, done, stall;
  logic        mapped, split;
  logic        c_byte, c_half, c_word;
  logic [31:0] acc_addr, rd_val;
  logic [3:0]  be;
  logic [7:0]  rd_byte;
  logic        unused_wc;

  gba_ws_decode #(
    .EWRAM_WS(EWRAM_WS),
    .VRAM_WS (VRAM_WS)
  ) u_dec (
    .addr_hi(bus.bus_addr[31:24]),
    .waitcnt(waitcnt[10:0]),
    .region (region),
    .width  (width),
    .n_ws   (n_ws),
    .s_ws   (s_ws)
  );

  assign unused_wc = ^waitcnt[15:11];
  assign mapped    = region != RG_NONE;
  assign split     = bus.bus_size == SIZE_WORD && width == BW_16;
  assign ws_first  = (bus.bus_addr == next_addr) ? s_ws : n_ws;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt;
    second_d  = second;
    lo_half_d = lo_half;
    issue     = 1'b0;
    hi        = second;
    stall     = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      IDLE: begin
        second_d = 1'b0;
        if (bus.bus_active) begin
          stall = 1'b1;
          if (ws_first == 4'd0) begin
            issue   = 1'b1;
            state_d = DATA;
          end else begin
            cnt_d   = ws_first - 4'd1;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!bus.bus_active) begin
          state_d  = IDLE;
          second_d = 1'b0;
        end else begin
          stall = 1'b1;
          if (cnt == 4'd0) begin
            issue   = 1'b1;
            state_d = second ? DATA2 : DATA;
          end else begin
            cnt_d = cnt - 4'd1;
          end
        end
      end
      DATA: begin
        if (!bus.bus_active) begin
          state_d = IDLE;
        end else if (split) begin
          // low half is back; the upper half is always sequential
          stall     = 1'b1;
          lo_half_d = mem_rdata[15:0];
          second_d  = 1'b1;
          if (s_ws == 4'd0) begin
            issue   = 1'b1;
            hi      = 1'b1;
            state_d = DATA2;
          end else begin
            cnt_d   = s_ws - 4'd1;
            state_d = WAIT;
          end
        end else begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      DATA2: begin
        state_d  = IDLE;
        second_d = 1'b0;
        done     = bus.bus_active;
      end
      default: state_d = IDLE;
    endcase
  end

  assign acc_addr = hi ? bus.bus_addr + 32'd2 : bus.bus_addr;

  assign c_byte = width == BW_8 || bus.bus_size == SIZE_BYTE;
  assign c_half = !c_byte &&
                  (bus.bus_size == SIZE_HALF || width == BW_16);
  assign c_word = !c_byte && !c_half;

  always_comb begin
    be = 4'b1111;
    unique case (1'b1)
      c_byte:  be = 4'b0001 << acc_addr[1:0];
      c_half:  be = acc_addr[1] ? 4'b1100 : 4'b0011;
      c_word:  be = 4'b1111;
      default: be = 4'b1111;
    endcase
  end

  assign rd_byte = mem_rdata[{bus.bus_addr[1:0], 3'b000} +: 8];

  always_comb begin
    if (!mapped) begin
`ifdef GBA_MEM_OPEN_BUS_EN
      rd_val = last_rd;
`else
      rd_val = 32'h0;
`endif
    end else if (state_q == DATA2) begin
      rd_val = {mem_rdata[31:16], lo_half};
    end else if (width == BW_8) begin
      rd_val = {4{rd_byte}};
    end else begin
      rd_val = mem_rdata;
    end
  end

  assign mem_en        = issue & mapped & rst_b;
  assign mem_we        = mem_en & bus.bus_wen;
  assign mem_be        = mem_en ? be : 4'b0000;
  assign mem_addr      = {acc_addr[31:2], 2'b00};
  assign mem_wdata     = bus.bus_wdata;
  assign bus.mem_wait  = stall & rst_b;
  assign bus.bus_rdata = done ? rd_val : last_rd;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q   <= IDLE;
      cnt       <= 4'd0;
      second    <= 1'b0;
      lo_half   <= 16'h0;
      next_addr <= 32'h0;
      last_rd   <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt     <= cnt_d;
      second  <= second_d;
      lo_half <= lo_half_d;
      if (done) begin
        next_addr <= bus.bus_addr + size_bytes(bus.bus_size);
        if (!bus.bus_wen) last_rd <= rd_val;
      end
    end
  end

endmodule

// File: tb/tb_gba_mem_responder.sv
// Directed bench for gba_mem_responder with a 1-cycle backing memory.
// Honours GBA_MEM_OPEN_BUS_EN for the unmapped-read expectation.
module tb_gba_mem_responder;
  import gba_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_b;
  logic [15:0] waitcnt;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic [31:0] rword [2];

  logic [31:0] log_addr [$];
  logic [3:0]  log_be   [$];
  logic        log_we   [$];
  logic [31:0] log_wd   [$];

  int nchk = 0;
  int npass = 0;
  int nfail = 0;
  int cyc;
  logic [31:0] rd, exp_ub;

  gba_mem_responder_if bus ();

  gba_mem_responder dut (
    .clk      (clk),
    .rst_b    (rst_b),
    .bus      (bus),
    .waitcnt  (waitcnt),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_be   (mem_be),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // upper-lane issues (be[2]) read rword[1], lower-lane ones rword[0]
  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= rword[mem_be[2]];
      log_addr.push_back(mem_addr);
      log_be.push_back(mem_be);
      log_we.push_back(mem_we);
      log_wd.push_back(mem_wdata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic clr_log();
    log_addr.delete();
    log_be.delete();
    log_we.delete();
    log_wd.delete();
  endtask

  task automatic access(input logic [31:0] a, input logic [1:0] sz,
                        input logic we, input logic [31:0] wd,
                        output int c, output logic [31:0] r);
    bit fin;
    @(negedge clk);
    clr_log();
    bus.bus_active = 1'b1;
    bus.bus_addr   = a;
    bus.bus_size   = sz;
    bus.bus_wen    = we;
    bus.bus_wdata  = wd;
    c   = 0;
    fin = 1'b0;
    r   = 32'h0;
    while (!fin && c < 40) begin
      c++;
      #1;
      if (!bus.mem_wait) begin
        r   = bus.bus_rdata;
        fin = 1'b1;
      end
      @(negedge clk);
    end
    bus.bus_active = 1'b0;
    chk("no_timeout", {31'b0, fin}, 32'd1);
  endtask

  initial begin
    rst_b          = 1'b0;
    waitcnt        = 16'h0;
    rword[0]       = 32'h0;
    rword[1]       = 32'h0;
    bus.bus_active = 1'b1;
    bus.bus_addr   = 32'h0300_0010;
    bus.bus_size   = SIZE_WORD;
    bus.bus_wen    = 1'b0;
    bus.bus_wdata  = 32'h0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_wait", {31'b0, bus.mem_wait}, 32'd0);
    chk("rst_en", {31'b0, mem_en}, 32'd0);
    chk("rst_be", {28'b0, mem_be}, 32'd0);
    chk("rst_rdata", bus.bus_rdata, 32'd0);
    @(negedge clk);
    rst_b          = 1'b1;
    bus.bus_active = 1'b0;

    rword[1] = 32'hDEAD_BEEF;
    access(32'h0300_0010, SIZE_WORD, 1'b0, 32'h0, cyc, rd);
    chk("iwram_cyc", cyc, 32'd2);
    chk("iwram_rd", rd, 32'hDEAD_BEEF);
    chk("iwram_nen", log_addr.size(), 32'd1);
    chk("iwram_be", {28'b0, log_be[0]}, 32'hF);
    chk("iwram_addr", log_addr[0], 32'h0300_0010);
    chk("iwram_we", {31'b0, log_we[0]}, 32'd0);

    access(32'h0600_0002, SIZE_HALF, 1'b1, 32'hABCD_0000, cyc, rd);
    chk("vram_cyc", cyc, 32'd2);
    chk("vram_nen", log_addr.size(), 32'd1);
    chk("vram_be", {28'b0, log_be[0]}, 32'hC);
    chk("vram_we", {31'b0, log_we[0]}, 32'd1);
    chk("vram_wd", {16'b0, log_wd[0][31:16]}, 32'hABCD);
    chk("vram_addr", log_addr[0], 32'h0600_0000);

    waitcnt  = 16'h0000;
    rword[0] = 32'h1111_5678;
    rword[1] = 32'hABCD_2222;
    access(32'h0800_0000, SIZE_WORD, 1'b0, 32'h0, cyc, rd);
    chk("gp_split_cyc", cyc, 32'd9);
    chk("gp_split_nen", log_addr.size(), 32'd2);
    chk("gp_lo_addr", log_addr[0], 32'h0800_0000);
    chk("gp_lo_be", {28'b0, log_be[0]}, 32'h3);
    chk("gp_hi_addr", log_addr[1], 32'h0800_0000);
    chk("gp_hi_be", {28'b0, log_be[1]}, 32'hC);
    chk("gp_split_rd", rd, 32'hABCD_5678);

    access(32'h0800_0004, SIZE_HALF, 1'b0, 32'h0, cyc, rd);
    chk("gp_seq_cyc", cyc, 32'd4);
    chk("gp_seq_rd", {16'b0, rd[15:0]}, 32'h5678);

    rword[0] = 32'h0000_1234;
    access(32'h0200_0000, SIZE_HALF, 1'b0, 32'h0, cyc, rd);
    chk("ewram_cyc", cyc, 32'd4);
    chk("ewram_rd", {16'b0, rd[15:0]}, 32'h1234);

`ifdef GBA_MEM_OPEN_BUS_EN
    exp_ub = 32'h0000_1234;
`else
    exp_ub = 32'h0;
`endif
    access(32'h1000_0000, SIZE_WORD, 1'b0, 32'h0, cyc, rd);
    chk("unmap_cyc", cyc, 32'd2);
    chk("unmap_nen", log_addr.size(), 32'd0);
    chk("unmap_rd", rd, exp_ub);

    access(32'h0F00_0000, SIZE_WORD, 1'b1, 32'h5555_AAAA, cyc, rd);
    chk("unmap_wr_cyc", cyc, 32'd2);
    chk("unmap_wr_nen", log_addr.size(), 32'd0);

    waitcnt  = 16'h0003;
    rword[1] = 32'h00AB_0000;
    access(32'h0E00_0002, SIZE_BYTE, 1'b0, 32'h0, cyc, rd);
    chk("sram_b_cyc", cyc, 32'd10);
    chk("sram_b_be", {28'b0, log_be[0]}, 32'h4);
    chk("sram_b_rd", rd, 32'hABAB_ABAB);

    waitcnt  = 16'h0002;
    rword[0] = 32'h0000_00C3;
    access(32'h0E00_0000, SIZE_WORD, 1'b0, 32'h0, cyc, rd);
    chk("sram_w_cyc", cyc, 32'd4);
    chk("sram_w_nen", log_addr.size(), 32'd1);
    chk("sram_w_be", {28'b0, log_be[0]}, 32'h1);
    chk("sram_w_rd", rd, 32'hC3C3_C3C3);

    waitcnt = 16'h0014;
    access(32'h0800_0100, SIZE_WORD, 1'b0, 32'h0, cyc, rd);
    chk("gp_s1_cyc", cyc, 32'd7);
    chk("gp_s1_nen", log_addr.size(), 32'd2);

    waitcnt = 16'h0000;
    @(negedge clk);
    clr_log();
    bus.bus_active = 1'b1;
    bus.bus_addr   = 32'h0C00_0000;
    bus.bus_size   = SIZE_HALF;
    bus.bus_wen    = 1'b0;
    repeat (2) @(negedge clk);
    bus.bus_active = 1'b0;
    #1;
    chk("abort_wait", {31'b0, bus.mem_wait}, 32'd0);
    repeat (6) @(negedge clk);
    chk("abort_nen", log_addr.size(), 32'd0);

    rword[1] = 32'hDEAD_BEEF;
    access(32'h0300_0020, SIZE_WORD, 1'b0, 32'h0, cyc, rd);
    chk("post_abort_cyc", cyc, 32'd2);
    chk("post_abort_rd", rd, 32'hDEAD_BEEF);

    @(negedge clk);
    bus.bus_active = 1'b1;
    bus.bus_addr   = 32'h0C00_0000;
    bus.bus_size   = SIZE_HALF;
    repeat (2) @(negedge clk);
    rst_b = 1'b0;
    #1;
    chk("rst_in_wait", {31'b0, bus.mem_wait}, 32'd0);
    chk("rst_in_en", {31'b0, mem_en}, 32'd0);
    chk("rst_clr_rd", bus.bus_rdata, 32'd0);
    @(negedge clk);
    rst_b          = 1'b1;
    bus.bus_active = 1'b0;

    access(32'h0300_0030, SIZE_WORD, 1'b0, 32'h0, cyc, rd);
    chk("post_rst_cyc", cyc, 32'd2);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
